// File: rtl/ab_mon_pkg.sv
// ---------------------------------------------------------------------------
// ab_mon_pkg
// Shared definitions for the a&&b in-circuit assertion monitor:
//   - ab_mon_state_e : monitor state encoding
//   - AB_CNT_W       : default width of violation / run-length counters
//   - AB_TS_W        : default width of the cycle timestamp counter
// ---------------------------------------------------------------------------
package ab_mon_pkg;

   localparam int AB_CNT_W = 16;
   localparam int AB_TS_W  = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHECK    = 2'd1,
      FAILING  = 2'd2,
      CLEARING = 2'd3
   } ab_mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (q -> 0)
//   clr  : synchronous clear, has priority over inc
//   inc  : increment request
//   q    : registered count, W bits
// ---------------------------------------------------------------------------
module sat_counter
   import ab_mon_pkg::*;
#(
   parameter int W = AB_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_r;

   // Count register: clear beats increment, increment stops at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r <= {W{1'b0}};
      end else if (clr) begin
         q_r <= {W{1'b0}};
      end else if (inc && (q_r != {W{1'b1}})) begin
         q_r <= q_r + W'(1'b1);
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/ab_assert_monitor.sv
// ---------------------------------------------------------------------------
// ab_assert_monitor
// Synthesizable checker for the invariant a && b, sampled on every enabled
// rising edge, with violation statistics and a four-phase host clear.
// Ports:
//   clk, rst     : clock / asynchronous active-high reset
//   en           : checking enable (nothing advances while low)
//   a, b         : monitored signals
//   clr_req      : host clear request (level); clr_ack : acknowledge
//   fail         : registered per-sample violation flag
//   err_sticky   : set on first violation until reset/clear
//   viol_cnt     : saturating violation count
//   first_ts     : cyc_ts value at the first violation
//   run_len      : current consecutive-violation run (saturating)
//   max_run      : longest run seen (saturating)
//   cyc_ts       : enabled-cycle counter, wrapping
// ---------------------------------------------------------------------------
module ab_assert_monitor
   import ab_mon_pkg::*;
#(
   parameter int CNT_W = AB_CNT_W,
   parameter int TS_W  = AB_TS_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             a,
   input  logic             b,
   input  logic             clr_req,
   output logic             clr_ack,
   output logic             fail,
   output logic             err_sticky,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [TS_W-1:0]  first_ts,
   output logic [CNT_W-1:0] run_len,
   output logic [CNT_W-1:0] max_run,
   output logic [TS_W-1:0]  cyc_ts
);

   ab_mon_state_e    state_r;
   ab_mon_state_e    state_nxt_s;
   logic             clr_ack_r;
   logic             ack_nxt_s;
   logic             pass_s;
   logic             sample_s;
   logic             viol_s;
   logic             run_clr_s;
   logic [CNT_W-1:0] viol_cnt_s;
   logic [CNT_W-1:0] run_len_s;
   logic [CNT_W-1:0] run_inc_s;
   logic [CNT_W-1:0] max_run_r;
   logic             fail_r;
   logic             err_sticky_r;
   logic [TS_W-1:0]  first_ts_r;
   logic [TS_W-1:0]  cyc_ts_r;

   // Pass decode: an X/Z on a or b makes the condition non-true, so it lands
   // in the else branch and counts as a violation.
   always_comb begin
      pass_s = 1'b0;
      if (a && b) begin
         pass_s = 1'b1;
      end else begin
         pass_s = 1'b0;
      end
   end

   // A sample is taken only when enabled, no clear is requested and the
   // clear handshake is not still in progress.
   always_comb begin
      sample_s = 1'b0;
      if (en && !clr_req && (state_r != CLEARING)) begin
         sample_s = 1'b1;
      end else begin
         sample_s = 1'b0;
      end
   end

   assign viol_s    = sample_s & ~pass_s;
   assign run_clr_s = clr_req | (sample_s & pass_s);

   // Run length after this edge's increment, saturated; feeds max_run.
   always_comb begin
      run_inc_s = run_len_s;
      if (run_len_s == {CNT_W{1'b1}}) begin
         run_inc_s = run_len_s;
      end else begin
         run_inc_s = run_len_s + CNT_W'(1'b1);
      end
   end

   sat_counter #(.W(CNT_W)) u_viol_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_req),
      .inc (viol_s),
      .q   (viol_cnt_s)
   );

   sat_counter #(.W(CNT_W)) u_run_len (
      .clk (clk),
      .rst (rst),
      .clr (run_clr_s),
      .inc (viol_s),
      .q   (run_len_s)
   );

   // State register plus registered clear acknowledge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         clr_ack_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         clr_ack_r <= ack_nxt_s;
      end
   end

   // Next-state logic. When enabled, the edge itself is a sample, so the
   // resumed state follows that sample: FAILING exactly when run_len > 0.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE, CHECK, FAILING: begin
            if (clr_req) begin
               state_nxt_s = CLEARING;
            end else if (!en) begin
               state_nxt_s = IDLE;
            end else if (pass_s) begin
               state_nxt_s = CHECK;
            end else begin
               state_nxt_s = FAILING;
            end
         end
         CLEARING: begin
            if (clr_req) begin
               state_nxt_s = CLEARING;
            end else if (en) begin
               state_nxt_s = CHECK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Output decode: acknowledge is held for every cycle spent in CLEARING.
   always_comb begin
      ack_nxt_s = 1'b0;
      if (state_nxt_s == CLEARING) begin
         ack_nxt_s = 1'b1;
      end else begin
         ack_nxt_s = 1'b0;
      end
   end

   // Timestamp, first-violation capture, max run and fail flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_ts_r     <= {TS_W{1'b0}};
         first_ts_r   <= {TS_W{1'b0}};
         err_sticky_r <= 1'b0;
         max_run_r    <= {CNT_W{1'b0}};
         fail_r       <= 1'b0;
      end else if (clr_req) begin
         cyc_ts_r     <= {TS_W{1'b0}};
         first_ts_r   <= {TS_W{1'b0}};
         err_sticky_r <= 1'b0;
         max_run_r    <= {CNT_W{1'b0}};
         fail_r       <= 1'b0;
      end else begin
         fail_r <= viol_s;
         if (sample_s) begin
            cyc_ts_r <= cyc_ts_r + TS_W'(1'b1);
         end else begin
            cyc_ts_r <= cyc_ts_r;
         end
         if (viol_s && !err_sticky_r) begin
            err_sticky_r <= 1'b1;
            first_ts_r   <= cyc_ts_r;
         end else begin
            err_sticky_r <= err_sticky_r;
            first_ts_r   <= first_ts_r;
         end
         if (viol_s && (run_inc_s > max_run_r)) begin
            max_run_r <= run_inc_s;
         end else begin
            max_run_r <= max_run_r;
         end
      end
   end

   assign clr_ack    = clr_ack_r;
   assign fail       = fail_r;
   assign err_sticky = err_sticky_r;
   assign viol_cnt   = viol_cnt_s;
   assign first_ts   = first_ts_r;
   assign run_len    = run_len_s;
   assign max_run    = max_run_r;
   assign cyc_ts     = cyc_ts_r;

endmodule

// File: tb/tb_ab_assert_monitor.sv
// ---------------------------------------------------------------------------
// tb_ab_assert_monitor
// Two monitors share stimulus: a default-width one and a narrow one
// (CNT_W=4, TS_W=4) that exercises saturation and timestamp wrap.
// The reference keeps the list of sampled outcomes of the current epoch and
// derives every statistic from that list.
// ---------------------------------------------------------------------------
module tb_ab_assert_monitor;
   import ab_mon_pkg::*;

   logic clk = 1'b0;
   logic rst, en, a, b, clr_req;

   logic        w_ack, w_fail, w_err;
   logic [15:0] w_viol, w_run, w_max;
   logic [31:0] w_first, w_cyc;
   logic        n_ack, n_fail, n_err;
   logic [3:0]  n_viol, n_run, n_max, n_first, n_cyc;

   int n_assert = 0;
   int n_fails  = 0;
   int nf;

   // Reference state: one entry per sample since reset/clear, 1 = violation.
   bit vq[$];
   bit m_fail, m_ack, m_clearing;

   always #5 clk = ~clk;

   ab_assert_monitor dut_w (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr_req(clr_req),
      .clr_ack(w_ack), .fail(w_fail), .err_sticky(w_err), .viol_cnt(w_viol),
      .first_ts(w_first), .run_len(w_run), .max_run(w_max), .cyc_ts(w_cyc)
   );

   ab_assert_monitor #(.CNT_W(4), .TS_W(4)) dut_n (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr_req(clr_req),
      .clr_ack(n_ack), .fail(n_fail), .err_sticky(n_err), .viol_cnt(n_viol),
      .first_ts(n_first), .run_len(n_run), .max_run(n_max), .cyc_ts(n_cyc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned sat(input longint unsigned v, input longint unsigned lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic check_all();
      longint unsigned cnt, run, mx, cur, first, sz;
      bit any;
      cnt = 0; run = 0; mx = 0; cur = 0; first = 0; any = 0;
      sz = vq.size();
      foreach (vq[i]) begin
         if (vq[i]) begin
            cnt++;
            cur++;
            if (cur > mx) mx = cur;
            if (!any) first = i;
            any = 1'b1;
         end else begin
            cur = 0;
         end
      end
      run = cur;
      check("w.fail",     {31'd0, w_fail}, {31'd0, m_fail});
      check("w.clr_ack",  {31'd0, w_ack},  {31'd0, m_ack});
      check("w.err",      {31'd0, w_err},  {31'd0, any});
      check("w.viol_cnt", {16'd0, w_viol}, 32'(sat(cnt, 64'd65535)));
      check("w.run_len",  {16'd0, w_run},  32'(sat(run, 64'd65535)));
      check("w.max_run",  {16'd0, w_max},  32'(sat(mx, 64'd65535)));
      check("w.first_ts", w_first,         32'(first));
      check("w.cyc_ts",   w_cyc,           32'(sz));
      check("n.fail",     {31'd0, n_fail}, {31'd0, m_fail});
      check("n.clr_ack",  {31'd0, n_ack},  {31'd0, m_ack});
      check("n.err",      {31'd0, n_err},  {31'd0, any});
      check("n.viol_cnt", {28'd0, n_viol}, 32'(sat(cnt, 64'd15)));
      check("n.run_len",  {28'd0, n_run},  32'(sat(run, 64'd15)));
      check("n.max_run",  {28'd0, n_max},  32'(sat(mx, 64'd15)));
      check("n.first_ts", {28'd0, n_first}, 32'(first % 16));
      check("n.cyc_ts",   {28'd0, n_cyc},  32'(sz % 16));
   endtask

   // Apply inputs for one edge, advance the reference, compare #1 after.
   task automatic step(input bit e, input bit ia, input bit ib, input bit c);
      en = e; a = ia; b = ib; clr_req = c;
      @(posedge clk);
      if (m_clearing) begin
         m_fail = 1'b0;
         if (c) begin
            m_ack = 1'b1;
         end else begin
            m_ack = 1'b0;
            m_clearing = 1'b0;
         end
      end else if (c) begin
         vq.delete();
         m_clearing = 1'b1;
         m_ack = 1'b1;
         m_fail = 1'b0;
      end else if (e) begin
         vq.push_back(!(ia && ib));
         m_fail = !(ia && ib);
      end else begin
         m_fail = 1'b0;
      end
      #1;
      check_all();
   endtask

   task automatic model_reset();
      vq.delete();
      m_fail = 1'b0; m_ack = 1'b0; m_clearing = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; clr_req = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; clr_req = 1'b0;
      model_reset();

      // Reset state, then 10 passing samples.
      do_reset();
      check("w.state_reset", 32'(dut_w.state_r), 32'(IDLE));
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      check("t1.cyc_ts",   w_cyc, 32'd10);
      check("t1.viol_cnt", {16'd0, w_viol}, 32'd0);
      check("t1.err",      {31'd0, w_err}, 32'd0);

      // Two passes, b low once, a low twice, recover.
      do_reset();
      nf = 0;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, !(i == 3 || i == 4), !(i == 2), 1'b0);
         if (w_fail) nf++;
      end
      check("t2.fail_cycles", nf, 32'd3);
      check("t2.viol_cnt", {16'd0, w_viol}, 32'd3);
      check("t2.first_ts", w_first, 32'd2);
      check("t2.max_run",  {16'd0, w_max}, 32'd3);
      check("t2.run_len",  {16'd0, w_run}, 32'd0);

      // Violations at samples 3-4 and 8-12.
      do_reset();
      for (int i = 0; i < 14; i++)
         step(1'b1, 1'b1, !(i == 3 || i == 4 || (i >= 8 && i <= 12)), 1'b0);
      check("t3.viol_cnt", {16'd0, w_viol}, 32'd7);
      check("t3.max_run",  {16'd0, w_max}, 32'd5);
      check("t3.first_ts", w_first, 32'd3);

      // Saturation on the narrow instance.
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      check("t4.n_viol", {28'd0, n_viol}, 32'd15);
      check("t4.n_run",  {28'd0, n_run},  32'd15);
      check("t4.n_max",  {28'd0, n_max},  32'd15);
      check("t4.w_viol", {16'd0, w_viol}, 32'd20);

      // Clear raised together with a violating sample.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("t5.ack_high", {31'd0, w_ack}, 32'd1);
      check("t5.viol_cnt", {16'd0, w_viol}, 32'd0);
      check("t5.cyc_ts",   w_cyc, 32'd0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("t5.ack_low", {31'd0, w_ack}, 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("t5.resume_cyc", w_cyc, 32'd1);

      // Asynchronous reset in the middle of a violation run.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      check("t6.state_w", 32'(dut_w.state_r), 32'(IDLE));
      check("t6.state_n", 32'(dut_n.state_r), 32'(IDLE));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomized traffic: enable gaps, clear handshakes, violation bursts.
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 24);
         if (r == 0) begin
            int k;
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++)
               step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, 1'b1);
            step($urandom_range(0, 1) == 1, 1'b1, 1'b1, 1'b0);
         end else if (r == 1) begin
            for (int j = 0; j < 18; j++) step(1'b1, 1'b0, 1'b1, 1'b0);
         end else begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fails);
      $finish;
   end

endmodule
